// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing a 4x16 register file between NREQ requesters, one op in flight.
// Latency: accept edge -> EXEC -> HOLD (write) / RESP (read, rsp_valid 2 cycles after accept).
// Backpressure: req_ready is offered only in IDLE; losers hold req_valid until granted.
module regfile_access_arbiter #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr1,
    input  logic [NREQ*ADDR_W-1:0]   req_addr2,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata1,
    output logic [DATA_W-1:0]        rsp_rdata2,
    output logic [ADDR_W-1:0]        rf_reg1,
    output logic [ADDR_W-1:0]        rf_reg2,
    output logic                     rf_write,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic [DATA_W-1:0]        rf_data1,
    input  logic [DATA_W-1:0]        rf_data2
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [ID_W-1:0]   ptr_q,     ptr_d;
    logic [ID_W-1:0]   owner_q,   owner_d;
    logic              wr_q,      wr_d;
    logic [ADDR_W-1:0] reg1_q,    reg1_d;
    logic [ADDR_W-1:0] reg2_q,    reg2_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              rfw_q,     rfw_d;
    logic [NREQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] rd1_q,     rd1_d;
    logic [DATA_W-1:0] rd2_q,     rd2_d;

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    int                scan_idx;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_a1;
    logic [ADDR_W-1:0] sel_a2;
    logic [DATA_W-1:0] sel_wd;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!grant_any && req_valid[ID_W'(scan_idx)]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(scan_idx);
            end
        end
        grant = '0;
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sel_write = req_write[grant_id];
        sel_a1    = ADDR_W'(req_addr1 >> (int'(grant_id) * ADDR_W));
        sel_a2    = ADDR_W'(req_addr2 >> (int'(grant_id) * ADDR_W));
        sel_wd    = DATA_W'(req_wdata >> (int'(grant_id) * DATA_W));
    end

    // Gated by reset so no grant is offered while reset is held.
    assign req_ready = (reset && (state_q == S_IDLE)) ? grant : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        wdata_d   = wdata_q;
        rfw_d     = 1'b0;
        rsp_vld_d = '0;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = S_EXEC;
                    owner_d = grant_id;
                    ptr_d   = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    wr_d    = sel_write;
                    reg1_d  = sel_a1;
                    reg2_d  = sel_a2;
                    wdata_d = sel_wd;
                    rfw_d   = sel_write;
                end
            end
            S_EXEC: begin
                if (wr_q) begin
                    state_d = S_HOLD;
                end else begin
                    state_d            = S_RESP;
                    rd1_d              = rf_data1;
                    rd2_d              = rf_data2;
                    rsp_vld_d[owner_q] = 1'b1;
                end
            end
            S_HOLD:  state_d = S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            wr_q      <= 1'b0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            wdata_q   <= '0;
            rfw_q     <= 1'b0;
            rsp_vld_q <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            wdata_q   <= wdata_d;
            rfw_q     <= rfw_d;
            rsp_vld_q <= rsp_vld_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
        end
    end

    assign rf_reg1       = reg1_q;
    assign rf_reg2       = reg2_q;
    assign rf_write_data = wdata_q;
    assign rf_write      = rfw_q;
    assign rsp_valid     = rsp_vld_q;
    assign rsp_rdata1    = rd1_q;
    assign rsp_rdata2    = rd2_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: vector table, directed multi-cycle sequences, randomized run vs. an op-level model.
module tb_regfile_access_arbiter;

    localparam int NREQ   = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [3:0]  req_addr1 = '0;
    logic [3:0]  req_addr2 = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [15:0] rsp_rdata1, rsp_rdata2, rf_write_data, rf_data1, rf_data2;
    logic [1:0]  rf_reg1, rf_reg2;
    logic        rf_write;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_access_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
        .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_write(rf_write),
        .rf_write_data(rf_write_data), .rf_data1(rf_data1), .rf_data2(rf_data2)
    );

    always #5 clk = ~clk;

    // Register file: combinational reads, commits data while the strobe is high at a rising edge.
    logic [15:0] rf_mem [4] = '{default: 16'h0};
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_reg1] <= rf_write_data;
    end
    assign rf_data1 = rf_mem[rf_reg1];
    assign rf_data2 = rf_mem[rf_reg2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [56:0] obs();
        return {req_ready, rsp_valid, rf_write, rf_reg1, rf_reg2, rf_write_data, rsp_rdata1, rsp_rdata2};
    endfunction

    // The strobe must never stay high across two sampled cycles.
    logic prev_rfw = 1'b0;
    always @(negedge clk) begin
        if (reset) check("rf_write_single", {63'b0, prev_rfw & rf_write}, 64'd0);
        prev_rfw <= reset ? rf_write : 1'b0;
    end

    typedef struct {
        logic        rst;
        logic [1:0]  vld, wr;
        logic [3:0]  a1, a2;
        logic [31:0] wd;
        logic [56:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [1:0] vld, input logic [1:0] wr,
                                input logic [3:0] a1, input logic [3:0] a2, input logic [31:0] wd,
                                input logic [1:0] rdy, input logic [1:0] rsp, input logic rfw,
                                input logic [1:0] r1, input logic [1:0] r2, input logic [15:0] rwd,
                                input logic [15:0] d1, input logic [15:0] d2);
        vec_t v;
        v.rst = rst; v.vld = vld; v.wr = wr; v.a1 = a1; v.a2 = a2; v.wd = wd;
        v.exp = {rdy, rsp, rfw, r1, r2, rwd, d1, d2};
        return v;
    endfunction

    int g_id [16];
    int g_cyc[16];
    int g_n;
    logic [1:0] rsp_seen;

    task automatic run_grants(input int n, input int sw, input logic [1:0] v0, input logic [1:0] v1);
        g_n = 0;
        rsp_seen = '0;
        for (int c = 0; c < n; c++) begin
            req_valid = (c < sw) ? v0 : v1;
            @(negedge clk);
            if (req_ready != 2'b00 && g_n < 16) begin
                g_id[g_n]  = (req_ready == 2'b10) ? 1 : ((req_ready == 2'b01) ? 0 : 9);
                g_cyc[g_n] = c;
                g_n++;
            end
            rsp_seen = rsp_seen | rsp_valid;
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    // Op-level reference model state for the randomized run.
    int          m_ptr, m_k, m_own, gid, cidx;
    logic        m_w;
    logic [1:0]  m_r1, m_r2, m_gnt, pend, exp_rdy, exp_rsp;
    logic [15:0] m_wd, m_d1, m_d2, m_p1, m_p2;
    logic [15:0] m_mem [4];

    vec_t tbl [14];

    initial begin
        // P1: R0 writes reg2<=BEEF, R1 reads reg2/reg0.  P2: R0 writes reg3<=1234, R1 reads reg3/reg3.
        tbl[0]  = mk(0, 2'b11, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b00, 2'b00, 0, 0, 0, 16'h0,    16'h0,    16'h0);
        tbl[1]  = mk(1, 2'b11, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b01, 2'b00, 0, 0, 0, 16'h0,    16'h0,    16'h0);
        tbl[2]  = mk(1, 2'b10, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b00, 2'b00, 1, 2, 0, 16'hBEEF, 16'h0,    16'h0);
        tbl[3]  = mk(1, 2'b10, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b00, 2'b00, 0, 2, 0, 16'hBEEF, 16'h0,    16'h0);
        tbl[4]  = mk(1, 2'b10, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b10, 2'b00, 0, 2, 0, 16'hBEEF, 16'h0,    16'h0);
        tbl[5]  = mk(1, 2'b00, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b00, 2'b00, 0, 2, 0, 16'h0,    16'h0,    16'h0);
        tbl[6]  = mk(1, 2'b00, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b00, 2'b10, 0, 2, 0, 16'h0,    16'hBEEF, 16'h0);
        tbl[7]  = mk(1, 2'b00, 2'b01, 4'hA, 4'h0, 32'h0000_BEEF, 2'b00, 2'b00, 0, 2, 0, 16'h0,    16'hBEEF, 16'h0);
        tbl[8]  = mk(1, 2'b01, 2'b01, 4'hF, 4'hC, 32'h0000_1234, 2'b01, 2'b00, 0, 2, 0, 16'h0,    16'hBEEF, 16'h0);
        tbl[9]  = mk(1, 2'b10, 2'b01, 4'hF, 4'hC, 32'h0000_1234, 2'b00, 2'b00, 1, 3, 0, 16'h1234, 16'hBEEF, 16'h0);
        tbl[10] = mk(1, 2'b10, 2'b01, 4'hF, 4'hC, 32'h0000_1234, 2'b00, 2'b00, 0, 3, 0, 16'h1234, 16'hBEEF, 16'h0);
        tbl[11] = mk(1, 2'b10, 2'b01, 4'hF, 4'hC, 32'h0000_1234, 2'b10, 2'b00, 0, 3, 0, 16'h1234, 16'hBEEF, 16'h0);
        tbl[12] = mk(1, 2'b00, 2'b01, 4'hF, 4'hC, 32'h0000_1234, 2'b00, 2'b00, 0, 3, 3, 16'h0,    16'hBEEF, 16'h0);
        tbl[13] = mk(1, 2'b00, 2'b01, 4'hF, 4'hC, 32'h0000_1234, 2'b00, 2'b10, 0, 3, 3, 16'h0,    16'h1234, 16'h1234);

        for (int r = 0; r < 14; r++) begin
            reset = tbl[r].rst; req_valid = tbl[r].vld; req_write = tbl[r].wr;
            req_addr1 = tbl[r].a1; req_addr2 = tbl[r].a2; req_wdata = tbl[r].wd;
            @(negedge clk);
            check($sformatf("table_row%0d", r), {7'b0, obs()}, {7'b0, tbl[r].exp});
            @(posedge clk); #1;
        end

        // Both requesters writing reg1 continuously: strict alternation, 3 cycles apart, no responses.
        req_write = 2'b11; req_addr1 = 4'h5; req_addr2 = 4'h0; req_wdata = 32'h5555_AAAA;
        run_grants(18, 18, 2'b11, 2'b11);
        check("alt_count", 64'(g_n), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("alt_id%0d", k),  64'(g_id[k]),  64'(k % 2));
            check($sformatf("alt_cyc%0d", k), 64'(g_cyc[k]), 64'(3 * k));
        end
        check("alt_no_rsp", 64'(rsp_seen), 64'd0);

        // R1 alone for three reads, then R0 joins and must win (ptr wrapped to 0).
        req_write = 2'b00; req_addr1 = 4'b0110; req_addr2 = 4'b1011;
        run_grants(12, 9, 2'b10, 2'b11);
        check("solo_count", 64'(g_n), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("solo_id%0d", k),  64'(g_id[k]),  (k < 3) ? 64'd1 : 64'd0);
            check($sformatf("solo_cyc%0d", k), 64'(g_cyc[k]), 64'(3 * k));
        end

        // Reset during EXEC of an R0 read (ptr would be 1); then restart from ptr 0.
        req_write = 2'b00; req_addr1 = 4'b0010; req_addr2 = 4'b0011; req_valid = 2'b01;
        @(negedge clk);
        check("pre_reset_grant", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        #2 reset = 1'b0;
        #1 check("reset_async_outputs", {7'b0, obs()}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset_quiet%0d", c), 64'({req_ready, rsp_valid}), 64'd0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset_grant", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check("post_reset_exec", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("post_reset_rsp", 64'({rsp_valid, rsp_rdata1, rsp_rdata2}), 64'({2'b01, 16'hBEEF, 16'h1234}));

        // Randomized run against the op-level model, starting from a clean reset.
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        m_ptr = 0; m_k = 0; m_own = 0; m_w = 0; m_r1 = 0; m_r2 = 0; m_wd = 0;
        m_d1 = 0; m_d2 = 0; m_p1 = 0; m_p2 = 0; m_gnt = 0; pend = 0;
        m_mem[0] = 16'h0; m_mem[1] = 16'h5555; m_mem[2] = 16'hBEEF; m_mem[3] = 16'h1234;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt[i]) pend[i] = 1'b0;
                else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    req_write[i] = 1'($urandom);
                    req_addr1[i*2 +: 2] = 2'($urandom);
                    req_addr2[i*2 +: 2] = 2'($urandom);
                    req_wdata[i*16 +: 16] = 16'($urandom);
                end
            end
            req_valid = pend;
            @(negedge clk);
            exp_rdy = '0; gid = -1;
            if (m_k == 0) begin
                for (int j = 0; j < NREQ; j++) begin
                    cidx = (m_ptr + j) % NREQ;
                    if (gid < 0 && req_valid[cidx]) gid = cidx;
                end
                if (gid >= 0) exp_rdy[gid] = 1'b1;
            end
            exp_rsp = '0;
            if (m_k == 2 && !m_w) exp_rsp[m_own] = 1'b1;
            check($sformatf("rand_cyc%0d", cyc), {7'b0, obs()},
                  {7'b0, exp_rdy, exp_rsp, (m_k == 1) && m_w, m_r1, m_r2, m_wd, m_d1, m_d2});
            if (m_k == 0 && gid >= 0) begin
                m_k = 1; m_own = gid; m_w = req_write[gid];
                m_r1 = req_addr1[gid*2 +: 2]; m_r2 = req_addr2[gid*2 +: 2]; m_wd = req_wdata[gid*16 +: 16];
                m_ptr = (gid + 1) % NREQ;
                if (m_w) m_mem[m_r1] = m_wd;
                else begin m_p1 = m_mem[m_r1]; m_p2 = m_mem[m_r2]; end
            end else if (m_k == 1) begin
                m_k = 2;
                if (!m_w) begin m_d1 = m_p1; m_d2 = m_p2; end
            end else if (m_k == 2) begin
                m_k = 0;
            end
            m_gnt = exp_rdy;
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares the 4-entry x 16-bit register file (two combinational read ports, one level/edge-sensitive write strobe) between NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Sequences the write strobe so that address and data are stable on both strobe edges.
- Returns read data to the owning requester with a one-cycle valid pulse.

Parameters:
- NREQ, 2, number of requesters (2..4)
- DATA_W, 16, register data width
- ADDR_W, 2, register address width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_valid  in  NREQ  request pending, per requester
- req_write  in  NREQ  1 = write, 0 = read
- req_addr1  in  NREQ*ADDR_W  write address / read port 1 address (requester i at [i*ADDR_W +: ADDR_W])
- req_addr2  in  NREQ*ADDR_W  read port 2 address (ignored for writes)
- req_wdata  in  NREQ*DATA_W  write data
- req_ready  out  NREQ  one-hot grant; transfer when valid & ready
- rsp_valid  out  NREQ  one-cycle read-response pulse to owner
- rsp_rdata1  out  DATA_W  read data, port 1
- rsp_rdata2  out  DATA_W  read data, port 2
- rf_reg1  out  ADDR_W  to register file reg1 (write/read address)
- rf_reg2  out  ADDR_W  to register file reg2
- rf_write  out  1  to register file write strobe
- rf_write_data  out  DATA_W  to register file write_data
- rf_data1  in  DATA_W  from register file data1
- rf_data2  in  DATA_W  from register file data2

Behaviour:

Reset (reset=0, async):
- State goes to IDLE and the rr pointer to 0.
- req_ready, rsp_valid, rf_write, rf_reg1, rf_reg2, rf_write_data, rsp_rdata1 and rsp_rdata2 all go to 0.

FSM states:
- IDLE: req_ready is combinational, asserted for exactly one requester: the first i with req_valid[i]=1, scanning from pointer ptr upward modulo NREQ. It is all-zero if no valid request. On the accepting edge:
  - Capture op (write, addr1, addr2, wdata) and owner id into registers.
  - ptr <= owner+1 (mod NREQ).
  - Go to EXEC.
- EXEC (1 cycle):
  - rf_reg1 = addr1, rf_reg2 = addr2, rf_write_data = wdata, all registered outputs.
  - Write op: rf_write = 1; next state HOLD.
  - Read op: rf_write = 0; at end of cycle capture rf_data1 -> rsp_rdata1 and rf_data2 -> rsp_rdata2; next state RESP.
- HOLD (1 cycle, writes only):
  - rf_write = 0.
  - rf_reg1 and rf_write_data unchanged from EXEC, since the file samples on both strobe edges.
  - Next state IDLE.
- RESP (1 cycle, reads only):
  - rsp_valid[owner] = 1.
  - rsp_rdata1/rsp_rdata2 hold the captured values until the next read capture.
  - Next state IDLE.

Timing and invariants:
- req_ready is 0 outside IDLE.
- Throughput is one op per 3 cycles: accept edge, EXEC, HOLD/RESP.
- Read latency: rsp_valid is high 2 cycles after the accept edge.
- Write visibility: a read accepted in the IDLE after HOLD returns the new value.
- rf_write never high for two consecutive cycles.
- rf_reg1/rf_write_data change only on the edge into EXEC.
- rf_reg1, rf_reg2 and rf_write_data keep their last value in IDLE; they are not cleared.

Boundary conditions:
- Simultaneous valids: the lowest index at or after ptr wins. The loser keeps req_valid high (it must not drop it) and wins the next IDLE.
- Requester dropping req_valid before ready: legal, no op issued.
- Same requester back-to-back: granted again only if no other requester is valid (fairness).
- ptr wrap: owner NREQ-1 -> ptr 0.
- Reset mid-operation:
  - In-flight op abandoned; no rsp_valid is issued.
  - rf_write falls asynchronously. Register file content at that address is undefined after a reset during EXEC.
  - After reset release, the first accept happens no earlier than the first rising edge with reset=1.

Test Plan:
- Reset with req_valid=2'b11 held -> req_ready=0 while reset=0. After release: req_ready=2'b01, cycle+1 rf_write=1 for exactly 1 cycle, HOLD keeps rf_reg1/rf_write_data.
- R0 writes addr1=2, wdata=16'hBEEF -> EXEC: rf_reg1=2, rf_write_data=BEEF, rf_write=1. HOLD: rf_write=0, same rf_reg1/rf_write_data. Then R1 reads addr1=2, addr2=0 -> rsp_valid=2'b10 two cycles after accept, rsp_rdata1=BEEF, rsp_rdata2=0.
- Both requesters continuously valid for 6 grants -> grant sequence R0, R1, R0, R1, R0, R1, each grant 3 cycles apart, no rsp_valid for writes.
- Only R1 valid, 3 consecutive reads -> R1 granted every IDLE. Then raise R0 while R1 stays valid -> next grant R0 (ptr=0 after R1).
- Write 16'h1234 to reg 3, then read reg3/reg3 -> rsp_rdata1=rsp_rdata2=1234. Check rf_write is never high two cycles in a row across the run.
- Assert reset during EXEC of a read -> rsp_valid never pulses, all outputs 0 immediately. After release, a fresh request completes normally with ptr restarted at 0.
